data_memory_param: RTL

- Parametrised single-port synchronous data memory; the next generation of the CPU data memory.
- Width, depth and read-during-write mode are set by parameters.
- Adds a post-reset clear sweep with a ready flag, explicit read-enable with a valid pulse, and out-of-range/not-ready error flagging.
- Sits between the CPU datapath and the load/store path; one access per clock.

---
 rtl/data_memory_pkg.sv | 16 +
 rtl/data_memory_param_if.sv | 27 ++
 rtl/data_memory_core.sv | 29 ++
 rtl/data_memory_param.sv | 106 ++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the parametrised data memory.
// Holds the controller state encoding and the sweep counter width rule.
package data_memory_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // One bit wider than the address so the sweep counter can reach DEPTH
    // without wrapping when DEPTH == 2**ADDR_WIDTH.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Load/store port of the data memory: request from the CPU side,
// registered response and status from the memory side.
interface data_memory_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);

    logic [ADDR_WIDTH-1:0] in_addr;
    logic                  in_write_en;
    logic                  in_read_en;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_error;

    modport master (
        output in_addr, in_write_en, in_read_en, in_data,
        input  out_data, out_valid, out_ready, out_error
    );

    modport slave (
        input  in_addr, in_write_en, in_read_en, in_data,
        output out_data, out_valid, out_ready, out_error
    );

endinterface

// File: rtl/data_memory_core.sv
// Plain single-port RAM with registered read, written so synthesis infers
// a block RAM. Read-during-write behaviour is selected by WRITE_FIRST.
module data_memory_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 1024,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM primitives; the
    // controller's clear sweep provides the initial contents instead.
    // NOTE: non-blocking assignments here make the old-data read in the
    // same cycle as a write see the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= (WRITE_FIRST && we) ? wdata : mem[addr];
    end

endmodule

// File: rtl/data_memory_param.sv
// Data memory controller: post-reset clear sweep, range and readiness
// checking, and the registered valid/error strobes around the RAM core.
module data_memory_param
    import data_memory_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DEPTH          = 1024,
    parameter bit                    WRITE_FIRST    = 1'b1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input logic               clk,
    input logic               rst,
    data_memory_param_if.slave bus
);

    localparam int              CNT_W   = cnt_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  ready_q;
    logic                  valid_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  in_range;
    logic                  req;
    logic                  accept_wr;
    logic                  accept_rd;

    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;

    assign in_range  = {1'b0, bus.in_addr} < DEPTH_C;
    assign req       = bus.in_write_en | bus.in_read_en;
    assign accept_wr = ready_q & bus.in_write_en & in_range;
    assign accept_rd = ready_q & bus.in_read_en & in_range;

    // The sweep owns the RAM port while clearing; otherwise the user port
    // drives it, with out-of-range addresses parked at word 0.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        core_we    = accept_wr;
        core_addr  = in_range ? bus.in_addr : '0;
        core_wdata = bus.in_data;
        if (state == ST_CLEAR) begin
            core_we    = 1'b1;
            core_addr  = cnt[ADDR_WIDTH-1:0];
            core_wdata = INIT_VALUE;
        end
    end

    data_memory_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .WRITE_FIRST(WRITE_FIRST)
    ) u_core (
        .clk  (clk),
        .we   (core_we),
        .addr (core_addr),
        .wdata(core_wdata),
        .rdata(core_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            valid_q <= accept_rd;
            error_q <= req & ~(ready_q & in_range);
            // Keep the last delivered word once the valid pulse ends.
            if (valid_q) begin
                hold_q <= core_rdata;
            end
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_C) begin
                        state   <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data  = valid_q ? core_rdata : hold_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ready = ready_q;
    assign bus.out_error = error_q;

endmodule
